// File: rtl/fp32_pkg.sv
// Single-precision field layout, packed view and operand classification
// shared by the adder result stage and its bench-facing helpers.
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MANT_W   = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                    sign;
        logic [EXP_HI-EXP_LO:0]  exp;
        logic [MANT_W-1:0]       mant;
    } fp32_t;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    // is_zero covers denormals too: they are flushed by the result stage.
    function automatic fp_class_t classify(input fp32_t f);
        fp_class_t c;
        c.is_nan  = (f.exp == EXP_MAX) && (f.mant != '0);
        c.is_inf  = (f.exp == EXP_MAX) && (f.mant == '0);
        c.is_zero = (f.exp == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_add_skid_fifo2.sv
// Two-entry valid/ready queue with a registered in_ready and 1-bit wrapping
// pointers; the head is readable the cycle after it is written.
module fp_add_skid_fifo2 #(
    parameter int DATA_W = 35
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_in_ready;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count_nxt;

    assign w_push      = i_valid && r_in_ready;
    assign w_pop       = (r_count != 2'd0) && i_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < 2'd2);
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fp_add_result_stage.sv
// Special-case correction of a combinational FP32 adder result, queued for
// output with exception flags and saturating exception counters.
module fp_add_result_stage
    import fp32_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             _go,
    output logic             in_ready,
    input  logic [31:0]      Number1,
    input  logic [31:0]      Number2,
    input  logic [31:0]      Result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Out,
    output logic             flag_invalid,
    output logic             flag_overflow,
    output logic             flag_underflow,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic [CNT_W-1:0] overflow_cnt,
    output logic [CNT_W-1:0] underflow_cnt
);

    fp32_t      w_a;
    fp32_t      w_b;
    fp32_t      w_r;
    fp_class_t  w_ca;
    fp_class_t  w_cb;
    logic [8:0] w_emax_p1;
    logic [31:0] w_fix;
    logic       w_inv;
    logic       w_ovf;
    logic       w_unf;
    logic       w_accept;
    logic [34:0] w_head;

    logic [CNT_W-1:0] r_inv_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic [CNT_W-1:0] r_unf_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign w_a  = Number1;
    assign w_b  = Number2;
    assign w_r  = Result;
    assign w_ca = classify(w_a);
    assign w_cb = classify(w_b);

    always_comb begin
        w_fix     = w_r;
        w_inv     = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        w_emax_p1 = ((w_a.exp > w_b.exp) ? {1'b0, w_a.exp} : {1'b0, w_b.exp}) + 9'd1;
        if (w_ca.is_nan || w_cb.is_nan) begin
            w_fix = CANON_NAN;
            w_inv = 1'b1;
        end else if (w_ca.is_inf && w_cb.is_inf && (w_a.sign != w_b.sign)) begin
            w_fix = CANON_NAN;
            w_inv = 1'b1;
        end else if (w_ca.is_inf) begin
            w_fix = w_a;
        end else if (w_cb.is_inf) begin
            w_fix = w_b;
        end else if (w_ca.is_zero && w_cb.is_zero) begin
            w_fix = {w_a.sign & w_b.sign, 31'd0};
        end else if (w_ca.is_zero) begin
            w_fix = w_b;
        end else if (w_cb.is_zero) begin
            w_fix = w_a;
        end else if (w_r.exp == EXP_MAX) begin
            w_fix = {w_r.sign, EXP_MAX, 23'd0};
            w_ovf = 1'b1;
        end else if (w_r.exp == 8'd0) begin
            w_fix = 32'd0;
        // A result exponent above Emax+1 can only come from a wrapped renormalisation.
        end else if ({1'b0, w_r.exp} > w_emax_p1) begin
            w_fix = {w_r.sign, 31'd0};
            w_unf = 1'b1;
        end
    end

    assign w_accept = _go && in_ready;

    fp_add_skid_fifo2 #(.DATA_W(35)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_valid (_go),
        .o_ready (in_ready),
        .i_data  ({w_fix, w_inv, w_ovf, w_unf}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_head)
    );

    assign Out            = w_head[34:3];
    assign flag_invalid   = w_head[2];
    assign flag_overflow  = w_head[1];
    assign flag_underflow = w_head[0];

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inv_cnt <= '0;
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (cnt_clr) begin
            r_inv_cnt <= '0;
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (w_accept) begin
            if (w_inv) r_inv_cnt <= sat_inc(r_inv_cnt);
            if (w_ovf) r_ovf_cnt <= sat_inc(r_ovf_cnt);
            if (w_unf) r_unf_cnt <= sat_inc(r_unf_cnt);
        end
    end

    assign invalid_cnt   = r_inv_cnt;
    assign overflow_cnt  = r_ovf_cnt;
    assign underflow_cnt = r_unf_cnt;

endmodule
